bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. One iteration per clock. It sits directly upstream of the bcd_to_7seg decoder. Each 4-bit digit of its output drives one decoder instance (digit 0 drives the ones-place display). Every output digit is always in 0..9, so a downstream decoder's valid output is always 1.

---
 rtl/bin_to_bcd_seq.sv | 136 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one shift iteration per clock.
// Digit k of bcd_out sits in bits [4k+3:4k]; digit 0 is the ones place.
module bin_to_bcd_seq #(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int unsigned SW    = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W) + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_d;

   logic [BIN_W-1:0]   shreg;
   logic [BIN_W-1:0]   shreg_d;
   logic [SW-1:0]      scratch;
   logic [SW-1:0]      scratch_d;
   logic [SW-1:0]      corrected;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_d;
   logic               acc;
   logic               acc_d;
   logic               busy_d;
   logic               done_d;
   logic [SW-1:0]      bcd_d;
   logic               overflow_d;
   logic               last_iter;

   assign last_iter = (cnt == CNT_W'(BIN_W - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start)     state_d = SHIFT;
         SHIFT:   if (last_iter) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Add-3 correction of every scratch digit that is 5 or more
   always_comb begin
      corrected = scratch;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (scratch[4*k +: 4] >= 4'd5) begin
            corrected[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
         end
      end
   end

   // Output and datapath next values
   always_comb begin
      shreg_d    = shreg;
      scratch_d  = scratch;
      cnt_d      = cnt;
      acc_d      = acc;
      busy_d     = busy;
      done_d     = 1'b0;
      bcd_d      = bcd_out;
      overflow_d = overflow;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_d   = bin;
               scratch_d = '0;
               cnt_d     = '0;
               acc_d     = 1'b0;
               busy_d    = 1'b1;
            end
         end
         SHIFT: begin
            // {scratch, shreg} shifts left; the bit leaving the top digit marks overflow
            scratch_d = {corrected[SW-2:0], shreg[BIN_W-1]};
            shreg_d   = shreg << 1;
            acc_d     = acc | corrected[SW-1];
            cnt_d     = cnt + CNT_W'(1);
            if (last_iter) begin
               bcd_d      = scratch_d;
               overflow_d = acc_d;
               done_d     = 1'b1;
               busy_d     = 1'b0;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         acc      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
      end else begin
         shreg    <= shreg_d;
         scratch  <= scratch_d;
         cnt      <= cnt_d;
         acc      <= acc_d;
         busy     <= busy_d;
         done     <= done_d;
         bcd_out  <= bcd_d;
         overflow <= overflow_d;
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start3, start2;
   logic [7:0]  bin3, bin2;
   logic        busy3, busy2, done3, done2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;
   logic        ovf3, ovf2;

   int errors = 0;
   int checks = 0;
   logic sel2 = 1'b0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin(bin3),
      .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
   );

   logic        obs_busy, obs_done, obs_ovf;
   logic [11:0] obs_bcd;
   assign obs_busy = sel2 ? busy2 : busy3;
   assign obs_done = sel2 ? done2 : done3;
   assign obs_ovf  = sel2 ? ovf2  : ovf3;
   assign obs_bcd  = sel2 ? {4'h0, bcd2} : bcd3;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic nibbles_ok(input logic [11:0] v);
      logic ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (v[4*k +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Drive start for one edge (E0) and confirm busy rises
   task automatic launch(input logic [7:0] v);
      if (sel2) begin start2 = 1'b1; bin2 = v; end
      else      begin start3 = 1'b1; bin3 = v; end
      step();
      start2 = 1'b0;
      start3 = 1'b0;
      check("busy_after_start", obs_busy, 1'b1);
      check("done_after_start", obs_done, 1'b0);
   endtask

   // Walk the remaining busy window, then check the completion cycle
   task automatic finish(input string tag, input int window, input logic [11:0] exp_bcd,
                         input logic exp_ovf);
      logic bad = 1'b0;
      for (int i = 0; i < window; i++) begin
         step();
         if (obs_busy !== 1'b1 || obs_done !== 1'b0) bad = 1'b1;
      end
      check({tag, "_window"}, bad, 1'b0);
      step();
      check({tag, "_done"}, obs_done, 1'b1);
      check({tag, "_busy_low"}, obs_busy, 1'b0);
      check({tag, "_bcd"}, obs_bcd, exp_bcd);
      check({tag, "_ovf"}, obs_ovf, exp_ovf);
      check({tag, "_nibbles"}, nibbles_ok(obs_bcd), 1'b1);
   endtask

   // Confirm no done pulse appears for n cycles
   task automatic quiet(input string tag, input int n);
      logic seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         if (obs_done !== 1'b0) seen = 1'b1;
      end
      check(tag, seen, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start3 = 1'b0; start2 = 1'b0; bin3 = '0; bin2 = '0;
      step();
      step();
      check("rst_busy", busy3, 1'b0);
      check("rst_done", done3, 1'b0);
      check("rst_bcd", bcd3, 12'h000);
      check("rst_ovf", ovf3, 1'b0);
      rst = 1'b0;
      step();

      // Basic conversion with full latency check
      launch(8'd255);
      finish("c255", 7, 12'h255, 1'b0);
      step();
      check("c255_pulse_single", done3, 1'b0);

      launch(8'd0);   finish("c0",  7, 12'h000, 1'b0); step();
      launch(8'd99);  finish("c99", 7, 12'h099, 1'b0); step();
      launch(8'd10);  finish("c10", 7, 12'h010, 1'b0); step();

      // Back-to-back: restart in the done cycle
      launch(8'd37);
      finish("b2b_a", 7, 12'h037, 1'b0);
      launch(8'd200);
      finish("b2b_b", 7, 12'h200, 1'b0);
      step();

      // Start while busy is ignored
      launch(8'd128);
      step();
      start3 = 1'b1; bin3 = 8'd5;
      step();
      start3 = 1'b0; bin3 = 8'd77;
      check("ign_busy", busy3, 1'b1);
      finish("ign", 5, 12'h128, 1'b0);
      quiet("ign_no_second_done", 12);

      // Reset aborts a conversion
      launch(8'd255);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", busy3, 1'b0);
      check("abort_done", done3, 1'b0);
      check("abort_bcd", bcd3, 12'h000);
      check("abort_ovf", ovf3, 1'b0);
      quiet("abort_no_done", 20);
      launch(8'd42);
      finish("post_rst", 7, 12'h042, 1'b0);
      step();

      // Reset has priority over start
      rst = 1'b1; start3 = 1'b1; bin3 = 8'd9;
      step();
      rst = 1'b0; start3 = 1'b0;
      check("rst_prio_busy", busy3, 1'b0);
      quiet("rst_prio_no_done", 10);

      // Two-digit instance: overflow reports bin mod 100
      sel2 = 1'b1;
      launch(8'd200); finish("d2_200", 7, 12'h000, 1'b1); step();
      launch(8'd123); finish("d2_123", 7, 12'h023, 1'b1); step();
      launch(8'd99);  finish("d2_99",  7, 12'h099, 1'b0); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
